// File: rtl/cred_pkg.sv
// Shared constants for the credential entry block: FSM encoding, digit capacity
// and the flag-kind codes driven by the unlock stage.
package cred_pkg;
  localparam int MAX_DIGITS = 8;

  localparam logic [1:0] ST_ENTRY     = 2'd0;
  localparam logic [1:0] ST_FLAG_WAIT = 2'd1;
  localparam logic [1:0] ST_LOCKOUT   = 2'd2;
  localparam logic [1:0] ST_RELEASE   = 2'd3;

  localparam logic FLAG_WRONG_PW = 1'b0;
  localparam logic FLAG_LOCKOUT  = 1'b1;

  typedef logic [3:0] nibble_t;
endpackage

// File: rtl/credential_entry_if.sv
// Bus between the unlock stage / switch panel (master) and credential_entry (slave).
interface credential_entry_if;
  import cred_pkg::*;

  nibble_t digit_sw;
  logic    btn_enter;
  logic    btn_back;
  logic    resetCount;
  logic    flag;
  logic    flagSelect;
  logic [3:0] inputCount;
  nibble_t userNameInput0, userNameInput1, userNameInput2, userNameInput3;
  nibble_t passwordInput0, passwordInput1, passwordInput2, passwordInput3;
  logic    flagResolve;
  logic    lockout_active;

  modport master (
    output digit_sw, btn_enter, btn_back, resetCount, flag, flagSelect,
    input  inputCount, userNameInput0, userNameInput1, userNameInput2, userNameInput3,
           passwordInput0, passwordInput1, passwordInput2, passwordInput3,
           flagResolve, lockout_active
  );

  modport slave (
    input  digit_sw, btn_enter, btn_back, resetCount, flag, flagSelect,
    output inputCount, userNameInput0, userNameInput1, userNameInput2, userNameInput3,
           passwordInput0, passwordInput1, passwordInput2, passwordInput3,
           flagResolve, lockout_active
  );
endinterface

// File: rtl/btn_debounce.sv
// Synchronises and debounces one raw push-button, emitting a single-cycle pulse
// on each accepted 0->1 transition.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pressed
);
  logic [1:0]  sync_q;
  logic        stable_q;
  logic [19:0] cnt_q;
  logic        pressed_q;
  logic        accept;

  // cnt_q counts consecutive samples that disagree with the accepted level
  assign accept = (sync_q[1] != stable_q) &&
                  (({1'b0, cnt_q} + 21'd1) >= {1'b0, DEBOUNCE_CYCLES});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw};
      pressed_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q  <= sync_q[1];
        cnt_q     <= '0;
        pressed_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 20'd1;
      end
    end
  end

  assign pressed = pressed_q;
endmodule

// File: rtl/credential_entry.sv
// Collects up to eight digits (4 username + 4 password) from switches and buttons,
// and handles wrong-password acknowledge and timed lockout for the unlock stage.
module credential_entry
  import cred_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [31:0] LOCKOUT_CYCLES  = 32'd500000000
) (
  input  logic clk,
  input  logic rst_n,
  credential_entry_if.slave bus
);
  logic        enter_p, back_p;
  logic        rc_q, rc_edge;
  logic [1:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [MAX_DIGITS-1:0][3:0] digits_q, digits_d;
  logic [31:0] lk_q, lk_d;
  logic        flag_resolve;
  logic [2:0]  last_idx;
  logic        lk_done;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_enter), .pressed(enter_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_back), .pressed(back_p)
  );

  assign rc_edge  = bus.resetCount & ~rc_q;
  assign last_idx = count_q[2:0] - 3'd1;
  assign lk_done  = ({1'b0, lk_q} + 33'd1) >= {1'b0, LOCKOUT_CYCLES};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    digits_d     = digits_q;
    lk_d         = lk_q;
    flag_resolve = 1'b0;
    // A resetCount edge wins over any button pulse in the same cycle
    if (rc_edge) begin
      count_d  = '0;
      digits_d = '0;
    end
    case (state_q)
      ST_ENTRY: begin
        if (bus.flag) begin
          state_d  = (bus.flagSelect == FLAG_LOCKOUT) ? ST_LOCKOUT : ST_FLAG_WAIT;
          count_d  = '0;
          digits_d = '0;
          lk_d     = '0;
        end else if (!rc_edge) begin
          if (enter_p && (count_q < 4'(MAX_DIGITS))) begin
            digits_d[count_q[2:0]] = bus.digit_sw;
            count_d                = count_q + 4'd1;
          end else if (back_p && (count_q != 4'd0)) begin
            digits_d[last_idx] = 4'd0;
            count_d            = count_q - 4'd1;
          end
        end
      end
      ST_FLAG_WAIT: begin
        if (!bus.flag) begin
          state_d = ST_ENTRY;
        end else if (enter_p) begin
          flag_resolve = 1'b1;
          state_d      = ST_RELEASE;
        end
      end
      ST_LOCKOUT: begin
        if (!bus.flag) begin
          state_d = ST_ENTRY;
          lk_d    = '0;
        end else if (lk_done) begin
          flag_resolve = 1'b1;
          lk_d         = '0;
          state_d      = ST_RELEASE;
        end else begin
          lk_d = lk_q + 32'd1;
        end
      end
      ST_RELEASE: begin
        if (!bus.flag) state_d = ST_ENTRY;
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENTRY;
      count_q  <= '0;
      digits_q <= '0;
      lk_q     <= '0;
      rc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      digits_q <= digits_d;
      lk_q     <= lk_d;
      rc_q     <= bus.resetCount;
    end
  end

  // First entered digit is the username MSB nibble
  assign bus.inputCount     = count_q;
  assign bus.userNameInput3 = digits_q[0];
  assign bus.userNameInput2 = digits_q[1];
  assign bus.userNameInput1 = digits_q[2];
  assign bus.userNameInput0 = digits_q[3];
  assign bus.passwordInput3 = digits_q[4];
  assign bus.passwordInput2 = digits_q[5];
  assign bus.passwordInput1 = digits_q[6];
  assign bus.passwordInput0 = digits_q[7];
  assign bus.flagResolve    = flag_resolve;
  assign bus.lockout_active = (state_q == ST_LOCKOUT);
endmodule

// File: doc/credential_entry.md
CREDENTIAL_ENTRY -- requirements
Module: credential_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd1000000, stable cycles required before a raw button level is accepted.
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 32'd500000000, lockout duration in clk cycles after a third failed login.
REQ-003 SHALL have port clk  input  1  the single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port digit_sw  input  4  digit value from the slide switches.
REQ-006 SHALL have port btn_enter  input  1  raw push-button; appends digit_sw, or acknowledges a wrong-password flag.
REQ-007 SHALL have port btn_back  input  1  raw push-button; deletes the last entered digit.
REQ-008 SHALL have port resetCount  input  1  clear request from the unlock stage.
REQ-009 SHALL have ports flag, flagSelect  input  1 each  error flag and its kind from the unlock stage: 0 = wrong password, 1 = third failure.
REQ-010 SHALL have port inputCount  output  4  number of digits held, 0..8.
REQ-011 SHALL have ports userNameInput0..3 and passwordInput0..3  output  4 each  entered digits.
REQ-012 SHALL have port flagResolve  output  1  single-cycle acknowledge to the unlock stage.
REQ-013 SHALL have port lockout_active  output  1  high while the lockout timer runs.

Function
REQ-014 SHALL debounce btn_enter and btn_back: a new level is accepted only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-015 SHALL generate a one-cycle press pulse on each debounced 0->1 transition; holding a button yields exactly one pulse.
REQ-016 SHALL, in ENTRY, on an enter pulse with inputCount<8, store digit_sw as follows and increment inputCount:
  - count 0,1,2,3 -> userNameInput3,2,1,0 (first digit is the MSB nibble)
  - count 4,5,6,7 -> passwordInput3,2,1,0
REQ-017 SHALL ignore enter pulses when inputCount==8; the count saturates and the digits are unchanged.
REQ-018 SHALL, on a back pulse with inputCount>0, zero the most recently written digit and decrement inputCount; at 0 it SHALL do nothing.
REQ-019 SHALL clear inputCount and all eight digits one cycle after a 0->1 edge of resetCount. A held-high resetCount SHALL NOT block further entry.
REQ-020 SHALL give a resetCount edge priority over enter/back pulses in the same cycle; those pulses are dropped.
REQ-021 SHALL implement FSM states ENTRY, FLAG_WAIT, LOCKOUT, RELEASE with these transitions:
  - ENTRY -> FLAG_WAIT when flag=1, flagSelect=0
  - ENTRY -> LOCKOUT when flag=1, flagSelect=1
  - On entering either state, clear the count and all digits.
REQ-022 SHALL, in FLAG_WAIT, ignore back pulses; an enter pulse SHALL assert flagResolve for one cycle and move to RELEASE without storing a digit.
REQ-023 SHALL, in LOCKOUT:
  - hold lockout_active=1 and ignore all buttons
  - count LOCKOUT_CYCLES with a 32-bit counter starting at 0
  - on terminal count, pulse flagResolve for one cycle, clear the counter and lockout_active, and move to RELEASE
REQ-024 SHALL, in RELEASE, ignore buttons and return to ENTRY when flag==0; flagResolve SHALL be 0 in RELEASE.
REQ-025 SHALL, if flag falls in FLAG_WAIT or LOCKOUT without an acknowledge, return to ENTRY with no flagResolve pulse.
REQ-026 SHALL drive flagResolve high in no state other than the single acknowledge cycle.

Reset
REQ-027 SHALL, on rst_n low, immediately force:
  - inputCount=0, all digits=0, flagResolve=0, lockout_active=0
  - state=ENTRY, lockout counter=0, debouncers at stable 0, resetCount edge register=0
REQ-028 SHALL, on reset mid-lockout, abandon the lockout with no flagResolve; the first debounced press after release is processed normally.

Structure
REQ-029 SHALL place the FSM state encoding, MAX_DIGITS=8, and the flagSelect codes in a shared package, cred_pkg.
REQ-030 SHALL implement debouncing in one sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw, pressed), instantiated twice.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=100)
REQ-031 SHALL cover: enter digits 1,1,0,0,1,1,0,0 -> inputCount=8; username nibbles {3,2,1,0}=1,1,0,0; password nibbles {3,2,1,0}=1,1,0,0.
REQ-032 SHALL cover: a ninth enter with digit_sw=4'hF -> inputCount stays 8, digits unchanged; then back -> inputCount=7, passwordInput0=0.
REQ-033 SHALL cover: a 2-cycle glitch on btn_enter -> no store; a 50-cycle press -> exactly one store.
REQ-034 SHALL cover: resetCount held high 20 cycles with entries during it -> clear once, entries after the edge accepted; enter coinciding with the edge -> dropped.
REQ-035 SHALL cover: flag=1, flagSelect=0, count=8 -> count=0; an enter -> one flagResolve pulse; flag drops -> ENTRY.
REQ-036 SHALL cover: flag=1, flagSelect=1 -> lockout_active for 100 cycles, then one flagResolve pulse; rst_n low at cycle 50 -> no pulse, all outputs 0.
